// File: rtl/guitar_pkg.sv
// guitar_pkg: shared types and constants for the lane scoring path.
package guitar_pkg;
  typedef enum logic [1:0] {J_NONE, J_GOOD, J_PERF, J_MISS} judge_t;
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} add_state_t;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_F = 8'h09;
  localparam logic [7:0] KEY_G = 8'h0A;
  localparam int DEF_HIT_Y_MIN  = 400;
  localparam int DEF_HIT_Y_MAX  = 440;
  localparam int DEF_PERF_Y_MIN = 412;
  localparam int DEF_PERF_Y_MAX = 428;
  typedef struct packed {
    logic [3:0] player;
    logic [3:0] points;
  } score_evt_t;
endpackage

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: adds a single-digit value to a BCD bank one digit per cycle, saturating to all 9s.
module bcd_serial_adder
  import guitar_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [DIGITS*4-1:0] operand,
  input  logic [3:0]          addend,
  output logic                busy,
  output logic                done,
  output logic [DIGITS*4-1:0] result
);
  localparam int CW = $clog2(DIGITS + 1);
  add_state_t          st;
  logic [DIGITS*4-1:0] acc;
  logic [3:0]          add;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic [4:0]          sum;
  logic [3:0]          dig;
  assign sum    = 5'(acc[3:0]) + 5'(add) + 5'(carry);
  assign dig    = (sum > 5'd9) ? 4'(sum - 5'd10) : sum[3:0];
  assign busy   = st != S_IDLE;
  assign done   = st == S_DONE;
  assign result = carry ? {DIGITS{4'h9}} : acc;
  // acc rotates right one digit per ADD cycle, so after DIGITS cycles it is back in order
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st    <= S_IDLE;
      acc   <= '0;
      add   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (st)
        S_IDLE: if (start) begin
          acc   <= operand;
          add   <= addend;
          carry <= 1'b0;
          cnt   <= '0;
          st    <= S_ADD;
        end
        S_ADD: begin
          acc   <= {dig, acc[DIGITS*4-1:4]};
          carry <= sum > 5'd9;
          add   <= '0;
          cnt   <= cnt + 1'b1;
          st    <= (cnt == CW'(DIGITS - 1)) ? S_DONE : S_ADD;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/lane_hit_scorer.sv
// lane_hit_scorer: judges key presses against note lanes, tracks combo/multiplier
// and accumulates per-player BCD scores through one shared serial adder.
module lane_hit_scorer
  import guitar_pkg::*;
#(
  parameter int NUM_LANES      = 5,
  parameter int NUM_PLAYERS    = 2,
  parameter int Y_W            = 10,
  parameter int HIT_Y_MIN      = DEF_HIT_Y_MIN,
  parameter int HIT_Y_MAX      = DEF_HIT_Y_MAX,
  parameter int PERF_Y_MIN     = DEF_PERF_Y_MIN,
  parameter int PERF_Y_MAX     = DEF_PERF_Y_MAX,
  parameter int SCORE_DIGITS   = 4,
  parameter int COMBO_PER_MULT = 4,
  parameter int MAX_MULT       = 4,
  parameter logic [NUM_LANES*8-1:0] LANE_KEYS = {KEY_G, KEY_F, KEY_D, KEY_S, KEY_A}
) (
  input  logic                                    Clk,
  input  logic                                    Reset,
  input  logic                                    frame_tick,
  input  logic [NUM_LANES*Y_W-1:0]                lane_y,
  input  logic [NUM_LANES-1:0]                    lane_active,
  input  logic [7:0]                              keycode,
  input  logic [$clog2(NUM_PLAYERS)-1:0]          active_player,
  output logic [NUM_PLAYERS*SCORE_DIGITS*4-1:0]   score_bcd,
  output logic [7:0]                              combo,
  output logic [2:0]                              multiplier,
  output logic [NUM_LANES-1:0]                    hit_pulse,
  output logic [NUM_LANES-1:0]                    miss_pulse,
  output logic [1:0]                              judge,
  output logic                                    busy,
  output logic                                    drop_flag
);
  localparam int BW = SCORE_DIGITS * 4;
  logic [7:0]                         prev_key;
  logic [$clog2(NUM_PLAYERS)-1:0]     prev_player;
  logic [NUM_LANES-1:0]               consumed, press, in_perf, hit_v, pass_v, clr, miss_v;
  logic                               any_hit, any_miss, perf, take, accept, done, pend_valid;
  logic [7:0]                         mstep;
  logic [3:0]                         pts, add_player;
  score_evt_t                         new_evt, pend_evt;
  logic [BW-1:0]                      operand, result;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [Y_W-1:0] y;
    assign y         = lane_y[i*Y_W +: Y_W];
    assign press[i]  = (keycode != prev_key) && (keycode == LANE_KEYS[i*8 +: 8]);
    assign in_perf[i] = (y >= Y_W'(PERF_Y_MIN)) && (y <= Y_W'(PERF_Y_MAX));
    assign hit_v[i]  = press[i] && lane_active[i] && !consumed[i]
                       && (y >= Y_W'(HIT_Y_MIN)) && (y <= Y_W'(HIT_Y_MAX));
    assign pass_v[i] = frame_tick && lane_active[i] && !consumed[i] && (y > Y_W'(HIT_Y_MAX));
    assign clr[i]    = !lane_active[i] || (y < Y_W'(HIT_Y_MIN));
  end
  assign miss_v     = (press & ~hit_v) | pass_v;
  assign any_hit    = |hit_v;
  assign any_miss   = |miss_v;
  assign perf       = |(hit_v & in_perf);
  assign mstep      = combo / 8'(COMBO_PER_MULT);
  assign multiplier = (mstep >= 8'(MAX_MULT - 1)) ? 3'(MAX_MULT) : 3'(mstep + 8'd1);
  assign pts        = perf ? {multiplier, 1'b0} : {1'b0, multiplier};
  assign new_evt    = {4'(active_player), pts};
  assign take       = pend_valid && !busy;
  // a full buffer can still accept when the adder drains it this very cycle
  assign accept     = any_hit && (!pend_valid || take);
  assign operand    = score_bcd[pend_evt.player*BW +: BW];
  bcd_serial_adder #(.DIGITS(SCORE_DIGITS)) u_add (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (take),
    .operand (operand),
    .addend  (pend_evt.points),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_key    <= '0;
      prev_player <= '0;
      consumed    <= '0;
      hit_pulse   <= '0;
      miss_pulse  <= '0;
      combo       <= '0;
      judge       <= J_NONE;
      pend_valid  <= 1'b0;
      pend_evt    <= '0;
      drop_flag   <= 1'b0;
      add_player  <= '0;
      score_bcd   <= '0;
    end else begin
      prev_key    <= keycode;
      prev_player <= active_player;
      consumed    <= (consumed | hit_v | pass_v) & ~clr;
      hit_pulse   <= hit_v;
      miss_pulse  <= miss_v;
      combo       <= (active_player != prev_player) ? 8'd0 :
                     any_hit ? ((combo == 8'hFF) ? combo : combo + 8'd1) :
                     any_miss ? 8'd0 : combo;
      judge       <= any_hit ? (perf ? J_PERF : J_GOOD) : any_miss ? J_MISS : judge;
      pend_valid  <= accept || (pend_valid && !take);
      if (accept) pend_evt <= new_evt;
      if (any_hit && !accept) drop_flag <= 1'b1;
      if (take) add_player <= pend_evt.player;
      if (done) score_bcd[add_player*BW +: BW] <= result;
    end
  end
endmodule

// File: tb/tb_lane_hit_scorer.sv
// tb_lane_hit_scorer: scenario tasks with a score scoreboard fed by a bench-side scoring model.
module tb_lane_hit_scorer;
  import guitar_pkg::*;
  logic        Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0;
  logic [49:0] lane_y = '0;
  logic [4:0]  lane_active = '0;
  logic [7:0]  keycode = '0;
  logic        active_player = 1'b0;
  logic [31:0] score_bcd;
  logic [7:0]  combo;
  logic [2:0]  multiplier;
  logic [4:0]  hit_pulse, miss_pulse;
  logic [1:0]  judge;
  logic        busy, drop_flag;
  int          n_cmp = 0, n_bad = 0;
  int          ms[2];
  int          mc;
  logic [31:0] q[$];
  logic [31:0] prev_score, e;
  logic [7:0]  keys[5];

  lane_hit_scorer dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .lane_y(lane_y),
    .lane_active(lane_active), .keycode(keycode), .active_player(active_player),
    .score_bcd(score_bcd), .combo(combo), .multiplier(multiplier),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .judge(judge),
    .busy(busy), .drop_flag(drop_flag)
  );

  always #5 Clk = ~Clk;

  function automatic int mult_of(input int c);
    return (1 + c / 4 > 4) ? 4 : 1 + c / 4;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {to_bcd(ms[1]), to_bcd(ms[0])};
  endfunction

  // score scoreboard: every change of score_bcd must match the oldest expected value
  always @(negedge Clk) begin
    if (Reset) begin
      q.delete();
      prev_score = score_bcd;
    end else if (score_bcd !== prev_score) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL score_unexpected: got %h, nothing expected", score_bcd);
      end else begin
        e = q.pop_front();
        if (score_bcd !== e) begin
          n_bad++;
          $display("FAIL score_update: got %h want %h", score_bcd, e);
        end
      end
      prev_score = score_bcd;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_hit(input bit perf, input bit push);
    int m = mult_of(mc);
    int pts = perf ? 2 * m : m;
    mc = (mc == 255) ? 255 : mc + 1;
    if (push) begin
      ms[active_player] = (ms[active_player] + pts > 9999) ? 9999 : ms[active_player] + pts;
      q.push_back(exp_vec());
    end
  endtask

  task automatic press(input int l, input int y);
    lane_y[l*10 +: 10] = 10'(y);
    lane_active[l] = 1'b1;
    keycode = keys[l];
    if (y >= 400 && y <= 440) model_hit(y >= 412 && y <= 428, 1'b1);
    else mc = 0;
    tick();
  endtask

  task automatic release_all();
    keycode = '0;
    lane_active = '0;
    tick();
  endtask

  task automatic settle();
    repeat (8) tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    n_cmp++; if (score_bcd !== 32'h0) begin n_bad++; $display("FAIL rst_score: got %h want 0", score_bcd); end
    n_cmp++; if (combo !== 8'd0) begin n_bad++; $display("FAIL rst_combo: got %0d want 0", combo); end
    n_cmp++; if (multiplier !== 3'd1) begin n_bad++; $display("FAIL rst_mult: got %0d want 1", multiplier); end
    n_cmp++; if (judge !== 2'd0) begin n_bad++; $display("FAIL rst_judge: got %0d want 0", judge); end
    n_cmp++; if ({hit_pulse, miss_pulse} !== 10'd0) begin n_bad++; $display("FAIL rst_pulses: got %b want 0", {hit_pulse, miss_pulse}); end
    n_cmp++; if ({busy, drop_flag} !== 2'b00) begin n_bad++; $display("FAIL rst_busy_drop: got %b want 00", {busy, drop_flag}); end
    tick();
    Reset = 1'b0;
    ms = '{0, 0};
    mc = 0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_perfect();
    press(0, 420);
    n_cmp++; if (hit_pulse !== 5'b00001) begin n_bad++; $display("FAIL perf_hit_pulse: got %b want 00001", hit_pulse); end
    n_cmp++; if (judge !== 2'd2) begin n_bad++; $display("FAIL perf_judge: got %0d want 2", judge); end
    n_cmp++; if (combo !== 8'd1) begin n_bad++; $display("FAIL perf_combo: got %0d want 1", combo); end
    release_all();
    n_cmp++; if (busy !== 1'b1 || hit_pulse !== 5'b0) begin n_bad++; $display("FAIL perf_busy_pulse: got %b/%b want 1/00000", busy, hit_pulse); end
    repeat (4) tick();
    n_cmp++; if (score_bcd !== 32'h0) begin n_bad++; $display("FAIL perf_early: got %h want 0", score_bcd); end
    tick();
    n_cmp++; if (score_bcd !== 32'h0000_0002 || busy !== 1'b0) begin n_bad++; $display("FAIL perf_latency: got %h busy %b want 00000002 busy 0", score_bcd, busy); end
    settle();
  endtask

  task automatic test_good_mult();
    for (int k = 0; k < 5; k++) begin
      press(2, 405);
      n_cmp++; if (judge !== 2'd1 || hit_pulse !== 5'b00100) begin n_bad++; $display("FAIL good_judge%0d: got %0d/%b want 1/00100", k, judge, hit_pulse); end
      n_cmp++; if (combo !== 8'(mc) || multiplier !== 3'(mult_of(mc))) begin n_bad++; $display("FAIL good_combo%0d: got %0d x%0d want %0d x%0d", k, combo, multiplier, mc, mult_of(mc)); end
      release_all();
      settle();
    end
  endtask

  task automatic test_bad_strum();
    press(1, 300);
    n_cmp++; if (miss_pulse !== 5'b00010 || hit_pulse !== 5'b0) begin n_bad++; $display("FAIL bad_pulses: got %b/%b want 00010/00000", miss_pulse, hit_pulse); end
    n_cmp++; if (combo !== 8'd0 || judge !== 2'd3 || multiplier !== 3'd1) begin n_bad++; $display("FAIL bad_state: got c%0d j%0d m%0d want c0 j3 m1", combo, judge, multiplier); end
    release_all();
    n_cmp++; if (miss_pulse !== 5'b0) begin n_bad++; $display("FAIL bad_pulse_len: got %b want 00000", miss_pulse); end
    settle();
  endtask

  task automatic test_pass_miss();
    lane_y[30 +: 10] = 10'd441;
    lane_active[3] = 1'b1;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    mc = 0;
    n_cmp++; if (miss_pulse !== 5'b01000 || judge !== 2'd3 || combo !== 8'd0) begin n_bad++; $display("FAIL pass_first: got %b j%0d c%0d want 01000 j3 c0", miss_pulse, judge, combo); end
    tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n_cmp++; if (miss_pulse !== 5'b0) begin n_bad++; $display("FAIL pass_again: got %b want 00000", miss_pulse); end
    lane_active[3] = 1'b0;
    tick();
    lane_y[30 +: 10] = 10'd450;
    lane_y[40 +: 10] = 10'd500;
    lane_active[4:3] = 2'b11;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n_cmp++; if (miss_pulse !== 5'b11000) begin n_bad++; $display("FAIL pass_multi: got %b want 11000", miss_pulse); end
    release_all();
    frame_tick = 1'b1;
    press(0, 440);
    frame_tick = 1'b0;
    n_cmp++; if (hit_pulse !== 5'b00001 || miss_pulse !== 5'b0) begin n_bad++; $display("FAIL pass_vs_hit: got %b/%b want 00001/00000", hit_pulse, miss_pulse); end
    release_all();
    settle();
  endtask

  task automatic test_window();
    int ys[8] = '{399, 400, 411, 412, 428, 429, 440, 441};
    int ej;
    for (int k = 0; k < 8; k++) begin
      ej = (ys[k] < 400 || ys[k] > 440) ? 3 : (ys[k] >= 412 && ys[k] <= 428) ? 2 : 1;
      press(0, ys[k]);
      n_cmp++; if (judge !== 2'(ej) || hit_pulse[0] !== (ej != 3)) begin n_bad++; $display("FAIL window_y%0d: got j%0d h%b want j%0d", ys[k], judge, hit_pulse[0], ej); end
      release_all();
      settle();
    end
  endtask

  task automatic test_back_to_back();
    lane_y[0 +: 30] = {10'd420, 10'd420, 10'd420};
    lane_active[2:0] = 3'b111;
    keycode = keys[0]; model_hit(1'b1, 1'b1); tick();
    keycode = keys[1]; model_hit(1'b1, 1'b1); tick();
    n_cmp++; if (drop_flag !== 1'b0) begin n_bad++; $display("FAIL drop_early: got %b want 0", drop_flag); end
    keycode = keys[2]; model_hit(1'b1, 1'b0); tick();
    n_cmp++; if (drop_flag !== 1'b1 || combo !== 8'(mc)) begin n_bad++; $display("FAIL drop_flag: got %b c%0d want 1 c%0d", drop_flag, combo, mc); end
    release_all();
    repeat (16) tick();
  endtask

  task automatic test_player();
    press(1, 300);
    release_all();
    for (int k = 0; k < 7; k++) begin
      press(0, 405);
      release_all();
      settle();
    end
    n_cmp++; if (combo !== 8'd7) begin n_bad++; $display("FAIL player_combo7: got %0d want 7", combo); end
    active_player = 1'b1;
    tick();
    mc = 0;
    n_cmp++; if (combo !== 8'd0) begin n_bad++; $display("FAIL player_switch: got %0d want 0", combo); end
    press(0, 420);
    release_all();
    settle();
    n_cmp++; if (score_bcd !== exp_vec()) begin n_bad++; $display("FAIL player_bank: got %h want %h", score_bcd, exp_vec()); end
    active_player = 1'b0;
    tick();
    mc = 0;
  endtask

  task automatic test_saturate();
    int rem, m;
    while (ms[0] < 9998) begin
      rem = 9998 - ms[0];
      m = mult_of(mc);
      if (rem >= 2 * m) press(0, 420);
      else if (rem >= m) press(0, 405);
      else press(1, 300);
      release_all();
      repeat (7) tick();
    end
    press(1, 300);
    release_all();
    press(0, 420);
    release_all();
    settle();
    n_cmp++; if (score_bcd[15:0] !== 16'h9999) begin n_bad++; $display("FAIL saturate: got %h want 9999", score_bcd[15:0]); end
  endtask

  task automatic test_reset_mid_add();
    press(0, 420);
    release_all();
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midadd_busy: got %b want 1", busy); end
    do_reset();
    repeat (8) tick();
    n_cmp++; if (score_bcd !== 32'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL midadd_after: got %h busy %b want 0 busy 0", score_bcd, busy); end
  endtask

  initial begin
    keys = '{KEY_A, KEY_S, KEY_D, KEY_F, KEY_G};
    ms = '{0, 0};
    mc = 0;
    test_reset();
    test_perfect();
    test_good_mult();
    test_bad_strum();
    test_pass_miss();
    test_window();
    test_back_to_back();
    test_player();
    test_saturate();
    test_reset_mid_add();
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL score_pending: got %0d outstanding want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lane_hit_scorer.md
Name: lane_hit_scorer

Overview:
- Parametrised successor to the fixed five-lane scoring path.
- Judges key presses against N note lanes using a hit window and a perfect window, and detects notes that pass unplayed.
- Maintains a combo count and a score multiplier, and accumulates BCD scores for P players in a multi-cycle digit-serial adder.
- Sits between the sprite lanes, the NIOS keycode and the HEX/colour-mapper consumers.

Parameters:
- NUM_LANES, 5, number of note lanes.
- NUM_PLAYERS, 2, number of score banks.
- Y_W, 10, lane y-position width.
- HIT_Y_MIN, 400, first y inside the hit window (inclusive).
- HIT_Y_MAX, 440, last y inside the hit window (inclusive).
- PERF_Y_MIN, 412, first y inside the perfect sub-window (inclusive).
- PERF_Y_MAX, 428, last y inside the perfect sub-window (inclusive).
- SCORE_DIGITS, 4, BCD digits per player.
- COMBO_PER_MULT, 4, consecutive hits needed per multiplier step.
- MAX_MULT, 4, multiplier ceiling.
- LANE_KEYS, {8'h0A,8'h09,8'h07,8'h16,8'h04}, packed HID codes; lane 0 is the low byte (A,S,D,F,G).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame
- lane_y  in  NUM_LANES*Y_W  packed note y per lane
- lane_active  in  NUM_LANES  note present in lane
- keycode  in  8  current USB keycode; 0 means no key
- active_player  in  $clog2(NUM_PLAYERS)  player currently scoring
- score_bcd  out  NUM_PLAYERS*SCORE_DIGITS*4  packed BCD banks
- combo  out  8  consecutive hits, saturates at 255
- multiplier  out  3  current multiplier, range 1..MAX_MULT
- hit_pulse  out  NUM_LANES  one-cycle pulse per judged hit
- miss_pulse  out  NUM_LANES  one-cycle pulse per miss
- judge  out  2  last judgement: 0 none, 1 good, 2 perfect, 3 miss
- busy  out  1  score adder running
- drop_flag  out  1  sticky: a score event was lost

Behaviour:
- Reset values:
  - all scores 0; combo 0; multiplier 1; judge 0
  - all pulses 0; busy 0; drop_flag 0
  - consumed[] 0; pending buffer empty; FSM in IDLE; prev_key 0
- Press detection:
  - prev_key is registered every cycle.
  - A press occurs when keycode != prev_key and keycode equals LANE_KEYS[L].
  - At most one lane is pressed per cycle.
  - Judgement registers on the cycle after the keycode change.
- Press judgement for lane L:
  - Hit: lane_active[L]=1, !consumed[L], and HIT_Y_MIN<=y<=HIT_Y_MAX.
    - Perfect if y is also within PERF_Y_MIN..PERF_Y_MAX: points = 2*mult.
    - Otherwise good: points = mult.
    - Sets consumed[L]; combo+1 (saturating); pulses hit_pulse[L].
  - Any other press is a bad strum: combo=0, judge=3, miss_pulse[L]; no score change.
- Pass-through miss: on frame_tick, for every lane with lane_active=1, !consumed and y>HIT_Y_MAX:
  - set consumed; pulse miss_pulse for that lane; combo=0; judge=3.
  - Several lanes missing on the same tick produce one combo reset and multiple pulses.
- consumed[L] clears when lane_active[L]=0 or y<HIT_Y_MIN.
- Simultaneous events: a hit and a frame_tick on the same lane in the same cycle resolve as the hit (the window excludes y>HIT_Y_MAX).
- Multiplier = min(1 + combo/COMBO_PER_MULT, MAX_MULT).
  - The value used for a hit is the one in effect before that hit's combo increment.
- combo resets to 0 when active_player changes.
- Score events: a hit forms {player, points}, with player sampled when the hit is judged.
- Score FSM states:
  - IDLE: empty → stays. Pending event present → load it, go to ADD.
  - ADD: one BCD digit per cycle, LSD first, with carry. Runs SCORE_DIGITS cycles, then goes to DONE.
  - DONE: one cycle; write back the bank. If the final carry is set, saturate the bank to all 9s. Return to IDLE.
- Latency from pending to updated score_bcd is SCORE_DIGITS+2 cycles.
- busy=1 in ADD and DONE.
- Pending buffer (1 entry):
  - Accepts an event when empty, or in the same cycle the FSM consumes it.
  - An event arriving while full is dropped and sets drop_flag; combo and pulses still update.
- Reset mid-ADD aborts the addition; the bank is cleared along with everything else.

Decomposition:
- Package guitar_pkg:
  - judge_t enum {J_NONE, J_GOOD, J_PERF, J_MISS}
  - HID key constants KEY_A/S/D/F/G
  - default window constants
  - score_evt_t struct {player, points[3:0]}
- Sub-module bcd_serial_adder: holds the FSM, the digit register and the carry. Handshake is start/busy/done; it is instantiated once and muxed over the banks.

Test Plan:
- Lane 0 y=420, active; keycode 0→0x04 → hit_pulse[0], judge=2, combo=1, P0 score 0002 after 6 cycles.
- Lane 2 y=405; keycode 0→0x07 → judge=1, score +1. Repeat 4 notes → multiplier=2; next good adds 2.
- Lane 1 y=300; press 0x16 → miss_pulse[1], combo=0, score unchanged. Lane 3 y=441 with frame_tick → miss_pulse[3], one pulse only on later ticks.
- Score 9998 with a perfect at mult 1 → saturates at 9999. Three hits within 3 cycles while busy → drop_flag=1.
- active_player=1 mid-combo 7 → combo=0; next hit credits bank 1 only.
- Assert Reset during ADD → all outputs return to reset values the next cycle, FSM in IDLE.
